// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;

  localparam int unsigned MIN_CLKS_PER_BIT = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/counter.sv
// Up-counter with synchronous clear-to-zero (load) taking priority over advance (en).
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (load_i) count_q <= '0;
    else if (en_i)   count_q <= count_q + WIDTH'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start/data/parity/stop sequencing with mid-bit sampling,
// valid/ready output register and single-cycle error pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] clks_per_bit,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state_q;
  logic                 rx_s;
  logic                 armed_q;
  logic [DIV_WIDTH-1:0] cpb_q, half_q, cpb_d;
  logic                 par_en_q, par_odd_q, par_bad_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 valid_q, ferr_q, perr_q, ovr_q;

  logic [DIV_WIDTH-1:0] timer;
  logic [IDX_W-1:0]     bit_idx;
  logic                 start_det, sample;
  logic                 timer_load, timer_en, idx_load, idx_en;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  counter #(.WIDTH(DIV_WIDTH)) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .en_i   (timer_en),
    .count_o(timer)
  );

  counter #(.WIDTH(IDX_W)) u_bit_index (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (idx_load),
    .en_i   (idx_en),
    .count_o(bit_idx)
  );

  always_comb begin
    cpb_d      = (clks_per_bit < DIV_WIDTH'(MIN_CLKS_PER_BIT)) ? DIV_WIDTH'(MIN_CLKS_PER_BIT)
                                                               : clks_per_bit;
    start_det  = (state_q == IDLE) && armed_q && !rx_s;
    sample     = 1'b0;
    case (state_q)
      START:             sample = (timer == (half_q - DIV_WIDTH'(1)));
      DATA, PARITY, STOP: sample = (timer == (cpb_q - DIV_WIDTH'(1)));
      default:           sample = 1'b0;
    endcase
    timer_load = start_det || sample;
    timer_en   = !timer_load && (state_q inside {START, DATA, PARITY, STOP});
    idx_load   = (state_q == START) && sample;
    idx_en     = (state_q == DATA) && sample && (bit_idx != LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      cpb_q     <= DIV_WIDTH'(MIN_CLKS_PER_BIT);
      half_q    <= DIV_WIDTH'(MIN_CLKS_PER_BIT / 2);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bad_q <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      // synchronizer resets low, so a start is only trusted once the idle-high line is seen
      armed_q <= armed_q | rx_s;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      if (valid_q && ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: if (start_det) begin
          cpb_q     <= cpb_d;
          half_q    <= cpb_d >> 1;
          par_en_q  <= parity_en;
          par_odd_q <= parity_odd;
          par_bad_q <= 1'b0;
          state_q   <= START;
        end
        START: if (sample) state_q <= rx_s ? IDLE : DATA;
        DATA: if (sample) begin
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) state_q <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (sample) begin
          par_bad_q <= ((^shift_q) ^ rx_s) != par_odd_q;
          state_q   <= STOP;
        end
        STOP: if (sample) begin
          if (!rx_s) begin
            ferr_q  <= 1'b1;
            state_q <= BREAK;
          end else begin
            if (par_bad_q)     perr_q <= 1'b1;
            else if (!valid_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else           ovr_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        BREAK:   if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign parity_err  = perr_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller: an FSM that sequences one input synchronizer and two up-counters to recover asynchronous serial frames. Each frame is a start bit, DATA_BITS data bits (LSB first), an optional parity bit and one stop bit. Bits are sampled at mid-bit using a run-time clocks-per-bit divisor. Received words are presented on a valid/ready interface to the host-side FIFO or register file. Error conditions are reported as single-cycle pulses.

## Interface
- DATA_BITS, 8, payload bits per frame (5..9)
- DIV_WIDTH, 16, width of clocks-per-bit divisor and bit-timer counter
- SYNC_STAGES, 3, flops in the rx synchronizer (>=2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  asynchronous serial line, idle high
- clks_per_bit  in  DIV_WIDTH  clk cycles per bit; latched at start detect; values <4 treated as 4
- parity_en  in  1  frame carries parity bit; latched at start detect
- parity_odd  in  1  1 = odd, 0 = even parity; latched at start detect
- data  out  DATA_BITS  received word; holds while valid
- valid  out  1  data holds an unconsumed word
- ready  in  1  consumer accepts data when valid&&ready
- framing_err  out  1  1-cycle pulse: stop bit sampled 0
- parity_err  out  1  1-cycle pulse: parity mismatch
- overrun  out  1  1-cycle pulse: good frame dropped because valid still high

## Operation
- rx passes through bit_synchronizer (SYNC_STAGES) to give rx_s. The synchronizer resets to 0, so an `armed` flag clears on reset. `armed` sets the first cycle rx_s==1. IDLE ignores rx_s==0 while unarmed, so there is no false start after reset.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: if armed && rx_s==0 → START. Same cycle: latch cpb=max(clks_per_bit,4), half=cpb>>1, parity config; bit timer := 0.
- START: sample when timer==half-1.
  - rx_s==1 → IDLE (glitch, no flag).
  - Else → DATA, timer:=0, bit index:=0.
- DATA: sample when timer==cpb-1 and shift rx_s into the MSB of the shift register (LSB-first line order). Timer:=0.
  - Bit index==DATA_BITS-1 → PARITY if parity_en, else STOP.
  - Otherwise bit index increments.
- PARITY: sample at timer==cpb-1.
  - Error if XOR(shift, sampled bit) != parity_odd.
  - → STOP.
- STOP: sample at timer==cpb-1.
  - 0 → framing_err pulse, frame dropped, → BREAK.
  - 1 with parity error → parity_err pulse, frame dropped, → IDLE.
  - 1, no error, valid==0 → load data, set valid, → IDLE.
  - 1, no error, valid==1 → overrun pulse, data/valid unchanged, → IDLE.
- BREAK: wait for rx_s==1, then → IDLE. A line held low is never re-detected as a start bit.
- Output handshake:
  - valid clears the cycle after valid&&ready.
  - Load and accept in the same cycle is impossible because a load requires valid==0.
- Latching rules:
  - Changes to clks_per_bit or parity configuration mid-frame have no effect until the next start.
  - The timer is DIV_WIDTH bits wide and never wraps, since cpb <= 2^DIV_WIDTH-1.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is lost. Re-arming requires rx_s==1.

## Timing
- Reset values:
  - state=IDLE, armed=0, valid=0, data=0.
  - framing_err=parity_err=overrun=0.
  - timer=0, bit index=0.
- rx_s lags rx by SYNC_STAGES cycles.
- Let T0 be the IDLE cycle with armed && rx_s==0. Then:
  - Start sample occurs at T0+half.
  - k-th subsequent sample (k=1..N) occurs at T0+half+k·cpb, where N=DATA_BITS+parity_en+1.
  - valid (or error pulse) asserts at T0+half+N·cpb+1.
- Example, 8N1 with cpb=16: valid at T0+153.
- Earliest next start detect: the cycle after the return to IDLE.
- All outputs are registered; no combinational path from rx or ready to any output.

## Structure
- Package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - localparam MIN_CLKS_PER_BIT = 4.
- Instances:
  - One bit_synchronizer.
  - Two counter instances: bit timer (WIDTH=DIV_WIDTH) and bit index (WIDTH=$clog2(DATA_BITS+1)). load clears to 0; en advances.
- No new sub-module; FSM, shift register and output register are inline.

## Test plan
- 8N1, cpb=16, send 0xA5, ready=1: valid pulses for 1 cycle at T0+153 with data=0xA5; no error pulses.
- Even parity, cpb=8, send 0x3C with wrong parity bit: parity_err pulses once; valid stays 0. Next frame 0x3C with correct parity: data=0x3C.
- Stop bit forced 0, then rx held low 100 cycles: framing_err pulses once; no second start detected until rx returns high.
- 3-cycle low glitch on idle rx, cpb=16: FSM returns to IDLE with no outputs.
- ready=0, send 0x11 then 0x22: data=0x11 held, overrun pulses at the second frame end. Raising ready clears valid the next cycle.
- Reset asserted mid-DATA with rx held low across reset release: no start detect until rx is seen high.
